// File: rtl/bb_msg_reader.sv
// bb_msg_reader: Avalon-MM master that polls the image processor's message
// FIFO, drains complete three-word bounding-box messages (ID, top-left,
// bottom-right), validates the ID word and presents the decoded corners on a
// valid/ready output.
// Optional build macro: BB_MSG_FLUSH_EN -- on an ID mismatch, write the
// FIFO-clear command to the status register instead of resyncing by re-polling.
module bb_msg_reader #(
    parameter int unsigned POLL_INTERVAL = 1024,
    parameter logic [31:0] MSG_ID        = 32'h00524242
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [2:0]  m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        bb_valid,
    input  logic        bb_ready,
    output logic [10:0] bb_x_min,
    output logic [10:0] bb_y_min,
    output logic [10:0] bb_x_max,
    output logic [10:0] bb_y_max,
    output logic [7:0]  err_count
);

    typedef enum logic [3:0] {
        IDLE, ST_REQ, ST_CAP, ID_REQ, ID_CAP, TL_REQ, TL_CAP, BR_REQ, BR_CAP, OUT
`ifdef BB_MSG_FLUSH_EN
        , FLUSH
`endif
    } state_t;

    localparam logic [15:0] TIMER_LOAD  = 16'(POLL_INTERVAL - 1);
    localparam logic [2:0]  ADDR_STATUS = 3'd0;
    localparam logic [2:0]  ADDR_MSG    = 3'd1;
`ifdef BB_MSG_FLUSH_EN
    localparam logic [31:0] FLUSH_CMD   = 32'h00000010;
`endif

    state_t      state;
    logic [15:0] timer;
    logic [10:0] tl_x;
    logic [10:0] tl_y;

    // Error counter sticks at its maximum instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Coordinate words carry x in [26:16] and y in [10:0]; other bits are ignored
    function automatic logic [10:0] hi_coord(input logic [31:0] w);
        return w[26:16];
    endfunction

    function automatic logic [10:0] lo_coord(input logic [31:0] w);
        return w[10:0];
    endfunction

    // Hold the top-left corner until the bottom-right word completes the message
    always_ff @(posedge clk) begin
        if (state == TL_CAP) begin
            tl_x <= hi_coord(m_readdata);
            tl_y <= lo_coord(m_readdata);
        end
    end

    // Poll/drain state machine; every bus and output signal is registered here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= TIMER_LOAD;
            m_read    <= 1'b0;
            m_address <= ADDR_STATUS;
            bb_valid  <= 1'b0;
            bb_x_min  <= '0;
            bb_y_min  <= '0;
            bb_x_max  <= '0;
            bb_y_max  <= '0;
            err_count <= '0;
`ifdef BB_MSG_FLUSH_EN
            m_write     <= 1'b0;
            m_writedata <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (timer == '0) begin
                        state     <= ST_REQ;
                        m_read    <= 1'b1;
                        m_address <= ADDR_STATUS;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                // Each *_REQ holds the read until accepted; *_CAP idles the bus
                // for one cycle so the slave sees a fresh rising read edge.
                ST_REQ: if (!m_waitrequest) begin state <= ST_CAP; m_read <= 1'b0; end
                ID_REQ: if (!m_waitrequest) begin state <= ID_CAP; m_read <= 1'b0; end
                TL_REQ: if (!m_waitrequest) begin state <= TL_CAP; m_read <= 1'b0; end
                BR_REQ: if (!m_waitrequest) begin state <= BR_CAP; m_read <= 1'b0; end
                ST_CAP: begin
                    if (m_readdata[15:8] >= 8'd3) begin
                        state     <= ID_REQ;
                        m_read    <= 1'b1;
                        m_address <= ADDR_MSG;
                    end else begin
                        state <= IDLE;
                        timer <= TIMER_LOAD;
                    end
                end
                ID_CAP: begin
                    if (m_readdata == MSG_ID) begin
                        state     <= TL_REQ;
                        m_read    <= 1'b1;
                        m_address <= ADDR_MSG;
                    end else begin
                        err_count <= sat_inc(err_count);
`ifdef BB_MSG_FLUSH_EN
                        state       <= FLUSH;
                        m_write     <= 1'b1;
                        m_address   <= ADDR_STATUS;
                        m_writedata <= FLUSH_CMD;
`else
                        // Re-poll at once; each attempt discards one stale word
                        state     <= ST_REQ;
                        m_read    <= 1'b1;
                        m_address <= ADDR_STATUS;
`endif
                    end
                end
                TL_CAP: begin
                    state     <= BR_REQ;
                    m_read    <= 1'b1;
                    m_address <= ADDR_MSG;
                end
                BR_CAP: begin
                    // Corners become visible only once the whole message is in
                    bb_x_min <= tl_x;
                    bb_y_min <= tl_y;
                    bb_x_max <= hi_coord(m_readdata);
                    bb_y_max <= lo_coord(m_readdata);
                    bb_valid <= 1'b1;
                    state    <= OUT;
                end
                OUT: begin
                    if (bb_ready) begin
                        bb_valid <= 1'b0;
                        state    <= IDLE;
                        timer    <= TIMER_LOAD;
                    end
                end
`ifdef BB_MSG_FLUSH_EN
                FLUSH: begin
                    if (!m_waitrequest) begin
                        m_write     <= 1'b0;
                        m_writedata <= '0;
                        state       <= IDLE;
                        timer       <= TIMER_LOAD;
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    timer  <= TIMER_LOAD;
                    m_read <= 1'b0;
                end
            endcase
        end
    end

`ifndef BB_MSG_FLUSH_EN
    assign m_write     = 1'b0;
    assign m_writedata = '0;
`endif

endmodule

// File: doc/bb_msg_reader.md
# bb_msg_reader

Avalon-MM master that drains bounding-box messages from the image processor's message FIFO on behalf of the rover control path. It polls the processor's status register, and when a complete three-word message is queued it reads it out, checks the message ID and delivers the decoded corner coordinates on a valid/ready output. Sits between the image processor's MM slave port and the drive/navigation logic, replacing CPU polling of the message FIFO.

## Interface
Parameters:
- POLL_INTERVAL, 1024: cycles spent in IDLE between status polls (>=1)
- MSG_ID, 32'h00524242: expected first word of a message (ASCII "RBB", zero-extended)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- m_address  out  3  word address: 0 status, 1 message, 2 ID, 3 box colour
- m_read  out  1  read request
- m_write  out  1  write request (flush; only with BB_MSG_FLUSH_EN)
- m_writedata  out  32  write data
- m_readdata  in  32  read data, valid exactly 1 cycle after read accepted
- m_waitrequest  in  1  slave stall; request held while high
- bb_valid  out  1  decoded box available
- bb_ready  in  1  consumer accepts box
- bb_x_min, bb_y_min, bb_x_max, bb_y_max  out  11 each  box corners
- err_count  out  8  ID-mismatch count, saturating at 255

## Operation
- States: IDLE, ST_REQ, ST_CAP, ID_REQ, ID_CAP, TL_REQ, TL_CAP, BR_REQ, BR_CAP, OUT, FLUSH.
- IDLE: 16-bit down-counter loaded with POLL_INTERVAL-1 on entry; at 0 -> ST_REQ.
- *_REQ: drive m_read=1 and the address (status 0, all others 1); hold until m_waitrequest=0, then -> matching *_CAP.
- *_CAP: m_read=0 (this idle cycle is mandatory: the slave pops its FIFO only on a rising read edge); capture m_readdata.
- ST_CAP: usedw = m_readdata[15:8]; usedw>=3 -> ID_REQ, else -> IDLE.
- ID_CAP: word==MSG_ID -> TL_REQ; mismatch -> err_count+1 (saturating), then FLUSH if BB_MSG_FLUSH_EN defined, else -> ST_REQ (resync by re-polling, no timer wait).
- TL_CAP: x_min=word[26:16], y_min=word[10:0]; upper bits ignored. BR_CAP: x_max/y_max the same way -> OUT.
- OUT: bb_valid=1, corners stable; on bb_valid & bb_ready -> IDLE. No reads are issued while OUT is held.
- Output registers update only on entering OUT; corner fields of a partially read message are never visible.
- No ID check is applied to the coordinate words; x_min>x_max (no detection in frame) is forwarded unchanged.

## Timing
- Reset: state IDLE, timer=POLL_INTERVAL-1, m_read=0, m_write=0, m_address=0, m_writedata=0, bb_valid=0, all bb_* =0, err_count=0.
- All outputs registered. Reset asserted mid-transaction aborts immediately; a message partially drained is lost (recovered by ID check).
- Zero-wait full message: ST_REQ..BR_CAP = 8 cycles; bb_valid rises the cycle after BR_CAP.
- Minimum m_read deasserted gap between any two reads: 1 cycle.
- bb_valid high with bb_ready high in the same cycle: handshake completes, bb_valid low next cycle.

## Configuration
- BB_MSG_FLUSH_EN defined: FLUSH state drives m_write=1, m_address=0, m_writedata=32'h00000010 until m_waitrequest=0, then -> IDLE; the slave's FIFO is cleared so stale words cannot misalign later messages.
- Undefined: FLUSH is absent, m_write and m_writedata tied 0; mismatch goes to ST_REQ and the block discards one word per resync attempt until aligned.

## Test plan
- POLL_INTERVAL=4, status usedw=0 -> only status reads, one every 6 cycles (4 idle + REQ + CAP); bb_valid stays 0.
- usedw=3, words 0x00524242, 0x0010_0020, 0x0050_0060, bb_ready=1 -> bb_x_min=16, bb_y_min=32, bb_x_max=80, bb_y_max=96, one bb_valid pulse.
- m_waitrequest high 3 cycles on TL_REQ -> m_read and m_address=1 held stable 4 cycles; data still decoded correctly; m_read low for ≥1 cycle between every read.
- ID word 0xDEADBEEF -> err_count=1; with BB_MSG_FLUSH_EN, one write of 0x10 to address 0; without it, next access is a status read.
- bb_ready=0 for 50 cycles after OUT -> outputs stable, no m_read issued; bb_ready=1 -> IDLE.
- reset_n low during BR_REQ -> all outputs at reset values asynchronously; next message decoded normally after reset.
